imem_loader: RTL

//  Writer side of the instruction memory. Receives a program as a byte stream

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 92 +++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: word geometry and
// the loader state encoding.
package imem_pkg;
  localparam int INSTR_W         = 24;
  localparam int ADDR_W          = 8;
  localparam int BYTES_PER_INSTR = INSTR_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    B0,
    B1,
    B2,
    WRITE,
    DONE
  } loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-RAM write port seen by the loader.
interface imem_loader_if;
  import imem_pkg::*;

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Assembles a length-prefixed byte stream into instruction words, writes them
// to RAM from address 0 and holds the CPU until the whole program is written.
module imem_loader
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done
);

  loader_state_t      r_state;
  loader_state_t      w_next;
  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W-1:0]  r_n;
  logic [ADDR_W-1:0]  r_addr_hold;
  logic [INSTR_W-1:0] r_data_hold;
  logic [7:0]         r_bytes [BYTES_PER_INSTR];
  logic [INSTR_W-1:0] w_word;
  logic [1:0]         w_slot;
  logic               w_ready;
  logic               w_xfer;
  logic               w_last;

  always_comb begin
    w_ready = (r_state == LEN) || (r_state == B0) ||
              (r_state == B1)  || (r_state == B2);
    w_xfer  = w_ready && bus.byte_valid;
    // N wraps: N=0 stands for a full 2**ADDR_W-word program.
    w_last  = (r_idx == ADDR_W'(r_n - 1'b1));
    w_word  = '0;
    for (int k = 0; k < BYTES_PER_INSTR; k++) begin
      w_word[INSTR_W-1-8*k -: 8] = r_bytes[k];
    end
    w_slot = 2'd0;
    case (r_state)
      B1:      w_slot = 2'd1;
      B2:      w_slot = 2'd2;
      default: w_slot = 2'd0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = LEN;
      LEN:     if (w_xfer) w_next = B0;
      B0:      if (w_xfer) w_next = B1;
      B1:      if (w_xfer) w_next = B2;
      B2:      if (w_xfer) w_next = WRITE;
      WRITE:   w_next = w_last ? DONE : B0;
      DONE:    if (start)  w_next = LEN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_n         <= '0;
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == LEN && w_xfer) begin
        r_n   <= bus.byte_data;
        r_idx <= '0;
      end
      if (r_state == WRITE) begin
        r_addr_hold <= r_idx;
        r_data_hold <= w_word;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Byte slots are pure data; the state machine decides when they are used.
  always_ff @(posedge clk) begin
    if (w_xfer && r_state != LEN) r_bytes[w_slot] <= bus.byte_data;
  end

  assign bus.byte_ready = w_ready;
  assign bus.wr_en      = (r_state == WRITE);
  assign bus.wr_addr    = (r_state == WRITE) ? r_idx  : r_addr_hold;
  assign bus.wr_data    = (r_state == WRITE) ? w_word : r_data_hold;
  assign cpu_hold       = (r_state != DONE);
  assign done           = (r_state == DONE);

endmodule
